branch_sequencer: RTL and testbench

- Instruction sequencer that sits directly upstream of jump_unit in the RISC core.
- Owns the program counter, the return-address register and the flag register.
- Fetches each instruction, then either issues it to the ALU datapath or pulses jump_unit and commits its PC_new/ra_new.
- Turns the combinational jump_unit into a multicycle fetch/decode/execute loop.

---
 rtl/branch_sequencer_if.sv | 32 +++
 rtl/branch_sequencer.sv | 80 ++++++++
 tb/tb_branch_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: fetch, datapath and jump_unit signals of the sequencer
interface branch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic        ex_done;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        jmp_ena;
  logic [3:0]  jmp_func;
  logic [21:0] jmp_addr;
  logic [3:0]  jmp_flags;
  logic [31:0] jmp_pc;
  logic [31:0] jmp_ra;
  logic [31:0] pc_new;
  logic [31:0] ra_new;
  logic [31:0] pc;
  logic        halted;
  modport master (
    output imem_req, imem_addr, ex_valid, ex_instr, jmp_ena, jmp_func, jmp_addr,
           jmp_flags, jmp_pc, jmp_ra, pc, halted,
    input  imem_ack, imem_data, ex_done, flags_we, flags_in, pc_new, ra_new
  );
  modport slave (
    input  imem_req, imem_addr, ex_valid, ex_instr, jmp_ena, jmp_func, jmp_addr,
           jmp_flags, jmp_pc, jmp_ra, pc, halted,
    output imem_ack, imem_data, ex_done, flags_we, flags_in, pc_new, ra_new
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: fetch/decode/execute loop owning pc, ra and flags around jump_unit
module branch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  BR_OPCODE   = 6'b111000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic clk,
  input logic rst_n,
  branch_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_JUMP, S_HALT} state_t;
  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ra;
  logic [31:0] r_ir;
  logic [3:0]  r_flags;
  logic [5:0]  w_opcode;
  logic [3:0]  w_func;
  logic        w_is_br;
  logic        w_is_halt;
  logic        w_jump_ok;
  assign w_opcode  = r_ir[31:26];
  assign w_func    = r_ir[25:22];
  assign w_is_br   = w_opcode == BR_OPCODE;
  assign w_is_halt = w_opcode == HALT_OPCODE;
  assign w_jump_ok = w_func <= 4'd10;
  // state register; reset drops any in-flight handshake immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = bus.imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_is_halt ? S_HALT :
                         w_is_br   ? (w_jump_ok ? S_JUMP : S_FETCH) : S_EXEC;
      S_EXEC:   w_next = bus.ex_done ? S_FETCH : S_EXEC;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  // control outputs are pure functions of the state
  always_comb begin
    bus.imem_req = r_state == S_FETCH;
    bus.ex_valid = r_state == S_EXEC;
    bus.jmp_ena  = r_state == S_JUMP;
    bus.halted   = r_state == S_HALT;
  end
  // architectural registers: IR capture, pc advance/redirect, ra on CALL, flags on ALU completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_ra    <= 32'd0;
      r_ir    <= 32'd0;
      r_flags <= 4'd0;
    end else begin
      if (r_state == S_FETCH && bus.imem_ack) r_ir <= bus.imem_data;
      if (r_state == S_DECODE && !w_is_halt && w_is_br && !w_jump_ok) r_pc <= r_pc + 32'd1;
      if (r_state == S_EXEC && bus.ex_done) begin
        r_pc <= r_pc + 32'd1;
        if (bus.flags_we) r_flags <= bus.flags_in;
      end
      if (r_state == S_JUMP) begin
        r_pc <= bus.pc_new;
        if (w_func == 4'd0) r_ra <= bus.ra_new;
      end
    end
  assign bus.imem_addr = r_pc;
  assign bus.ex_instr  = r_ir;
  assign bus.jmp_func  = w_func;
  assign bus.jmp_addr  = r_ir[21:0];
  assign bus.jmp_flags = r_flags;
  assign bus.jmp_pc    = r_pc;
  assign bus.jmp_ra    = r_ra;
  assign bus.pc        = r_pc;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized instruction stream checked against an architectural model
module tb_branch_sequencer;
  localparam logic [5:0] BR   = 6'b111000;
  localparam logic [5:0] HALT = 6'b111111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  branch_sequencer_if bus();
  branch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] m_pc = 32'd0, m_ra = 32'd0, m_ir = 32'd0;
  logic [3:0]  m_flags = 4'd0;
  logic e_req = 1'b0, e_exv = 1'b0, e_jmp = 1'b0, e_halt = 1'b0;
  logic [31:0] seen_ra;
  bit chk_en = 1'b0;
  int total = 0, bad = 0, n_exv = 0, n_jmp = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("ex_valid", 32'(bus.ex_valid), 32'(e_exv));
    chk("ex_instr", bus.ex_instr, m_ir);
    chk("jmp_ena", 32'(bus.jmp_ena), 32'(e_jmp));
    chk("jmp_func", 32'(bus.jmp_func), 32'(m_ir[25:22]));
    chk("jmp_addr", 32'(bus.jmp_addr), 32'(m_ir[21:0]));
    chk("jmp_flags", 32'(bus.jmp_flags), 32'(m_flags));
    chk("jmp_pc", bus.jmp_pc, m_pc);
    chk("jmp_ra", bus.jmp_ra, m_ra);
    chk("pc", bus.pc, m_pc);
    chk("halted", 32'(bus.halted), 32'(e_halt));
    n_exv += int'(bus.ex_valid);
    n_jmp += int'(bus.jmp_ena);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic noise();
    bus.imem_ack  = 1'($urandom);
    bus.imem_data = $urandom;
    bus.ex_done   = 1'($urandom);
    bus.flags_we  = 1'($urandom);
    bus.flags_in  = 4'($urandom);
    bus.pc_new    = $urandom;
    bus.ra_new    = $urandom;
  endtask
  task automatic run(input logic [31:0] ins, input int aw, input int dw, input logic fwe,
                     input logic [3:0] fin, input logic [31:0] pn, input logic [31:0] rn);
    logic [5:0] op;
    logic [3:0] fn;
    op = ins[31:26];
    fn = ins[25:22];
    e_req = 1'b1; e_exv = 1'b0; e_jmp = 1'b0; e_halt = 1'b0;
    repeat (aw) begin noise(); bus.imem_ack = 1'b0; cyc(); end
    noise(); bus.imem_ack = 1'b1; bus.imem_data = ins; cyc();
    m_ir = ins;
    e_req = 1'b0;
    noise(); cyc();
    if (op == HALT) begin
      e_halt = 1'b1;
      repeat (20) begin noise(); cyc(); end
    end else if (op == BR && fn > 4'd10) begin
      m_pc = m_pc + 32'd1;
    end else if (op == BR) begin
      e_jmp = 1'b1;
      noise(); bus.pc_new = pn; bus.ra_new = rn;
      seen_ra = bus.jmp_ra;
      cyc();
      m_pc = pn;
      if (fn == 4'd0) m_ra = rn;
      e_jmp = 1'b0;
    end else begin
      e_exv = 1'b1;
      repeat (dw) begin noise(); bus.ex_done = 1'b0; cyc(); end
      noise(); bus.ex_done = 1'b1; bus.flags_we = fwe; bus.flags_in = fin; cyc();
      m_pc = m_pc + 32'd1;
      if (fwe) m_flags = fin;
      e_exv = 1'b0;
    end
    e_req = op != HALT;
  endtask
  function automatic logic [31:0] alu_word();
    logic [5:0] op;
    op = 6'($urandom_range(0, 55));
    return {op, 26'($urandom)};
  endfunction
  initial begin
    logic [31:0] w;
    noise();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst_n = 1'b1;
    noise(); cyc();
    chk("first_fetch_req", 32'(bus.imem_req), 32'd1);
    chk("first_fetch_addr", bus.imem_addr, 32'd0);
    run({BR, 4'd1, 22'd4}, 0, 0, 1'b0, 4'd0, 32'd4, 32'd77);
    chk("jump_to_4_pc", bus.pc, 32'd4);
    chk("jump_to_4_ra", bus.jmp_ra, 32'd0);
    n_exv = 0;
    run(alu_word(), 0, 2, 1'b1, 4'b0001, 32'd0, 32'd0);
    chk("alu_exv_cycles", 32'(n_exv), 32'd3);
    chk("alu_pc", bus.pc, 32'd5);
    chk("alu_flags", 32'(bus.jmp_flags), 32'd1);
    run({BR, 4'd5, 22'd1}, 1, 0, 1'b0, 4'd0, 32'd1, 32'd3);
    n_jmp = 0;
    run({BR, 4'd0, 22'd25}, 0, 0, 1'b0, 4'd0, 32'd25, 32'd2);
    chk("call_jmp_pulses", 32'(n_jmp), 32'd1);
    chk("call_pc", bus.pc, 32'd25);
    chk("call_ra", bus.jmp_ra, 32'd2);
    run({BR, 4'd8, 22'd5}, 1, 0, 1'b0, 4'd0, 32'd5, 32'd99);
    chk("bz_pc", bus.pc, 32'd5);
    chk("bz_ra_kept", bus.jmp_ra, 32'd2);
    run({BR, 4'd0, 22'd40}, 0, 0, 1'b0, 4'd0, 32'd40, 32'd17);
    run({BR, 4'd10, 22'd0}, 2, 0, 1'b0, 4'd0, 32'd17, 32'd55);
    chk("ret_jmp_ra", seen_ra, 32'd17);
    chk("ret_pc", bus.pc, 32'd17);
    chk("ret_ra_kept", bus.jmp_ra, 32'd17);
    n_jmp = 0;
    run({BR, 4'd13, 22'd9}, 0, 0, 1'b0, 4'd0, 32'd123, 32'd456);
    chk("nop_no_jmp", 32'(n_jmp), 32'd0);
    chk("nop_pc", bus.pc, 32'd18);
    run({BR, 4'd7, 22'd0}, 0, 0, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd0);
    run(alu_word(), 0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("pc_wrap", bus.pc, 32'd0);
    repeat (250) begin
      if ($urandom_range(0, 2) != 0) w = {BR, 4'($urandom), 22'($urandom)};
      else w = alu_word();
      run(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 4'($urandom),
          $urandom, $urandom);
    end
    w = alu_word();
    e_req = 1'b1;
    noise(); bus.imem_ack = 1'b1; bus.imem_data = w; cyc();
    m_ir = w;
    e_req = 1'b0;
    noise(); cyc();
    e_exv = 1'b1;
    noise(); bus.ex_done = 1'b0; cyc();
    noise(); bus.ex_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, 32'd0);
    chk("async_rst_exv", 32'(bus.ex_valid), 32'd0);
    chk("async_rst_flags", 32'(bus.jmp_flags), 32'd0);
    m_pc = 32'd0; m_ra = 32'd0; m_ir = 32'd0; m_flags = 4'd0;
    e_req = 1'b0; e_exv = 1'b0; e_jmp = 1'b0; e_halt = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    noise(); cyc();
    e_req = 1'b1;
    chk("rst_fetch_req", 32'(bus.imem_req), 32'd1);
    chk("rst_fetch_addr", bus.imem_addr, 32'd0);
    run({HALT, 26'($urandom)}, 1, 0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_no_req", 32'(bus.imem_req), 32'd0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
